// File: rtl/dif_radix2_tm_gen.sv
// Twiddle multiplier between the two R-point stages of an R x R DIF radix-2 FFT.
// Exponent from a per-frame sample counter, octant-folded ROM, 3-stage valid/ready pipeline.
module dif_radix2_tm_gen #(
   parameter int DATA_WIDTH_IN  = 10,
   parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
   parameter int LOG2N          = 6,
   parameter int TW_WIDTH       = 12
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sof,
   input  logic                             inv,
   input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
   input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_sof,
   output logic                             out_last,
   output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
   output logic signed [DATA_WIDTH_OUT-1:0] dout_imag
);

   localparam int N      = 1 << LOG2N;
   localparam int H      = LOG2N / 2;
   localparam int NE     = N / 8;
   localparam int PW     = LOG2N - 3;
   localparam int MW     = LOG2N - 2;
   localparam int PRW    = DATA_WIDTH_IN + TW_WIDTH;
   localparam int SW     = PRW + 1;
   localparam int STAGES = 3;

   localparam logic signed [SW-1:0] RND  = SW'(2 ** (TW_WIDTH - 3));
   localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DATA_WIDTH_OUT - 1) - 1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   function automatic logic signed [TW_WIDTH-1:0] tw_val(input int m, input bit is_sin);
      real th, v;
      int  q;
      th = 6.283185307179586 * real'(m) / real'(N);
      v  = (is_sin ? $sin(th) : $cos(th)) * real'(2 ** (TW_WIDTH - 2));
      q  = $rtoi(v + 0.5);
      return q[TW_WIDTH-1:0];
   endfunction

   function automatic logic signed [DATA_WIDTH_OUT-1:0] rnd_sat(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] r;
      r = (v + RND) >>> (TW_WIDTH - 2);
      if (r > MAXV) return MAXV[DATA_WIDTH_OUT-1:0];
      if (r < MINV) return MINV[DATA_WIDTH_OUT-1:0];
      return r[DATA_WIDTH_OUT-1:0];
   endfunction

   // First octant of cos/sin, 0..pi/4 inclusive
   logic signed [TW_WIDTH-1:0] rom_c [0:NE];
   logic signed [TW_WIDTH-1:0] rom_s [0:NE];

   for (genvar g = 0; g <= NE; g++) begin : g_rom
      localparam logic signed [TW_WIDTH-1:0] CV = tw_val(g, 1'b0);
      localparam logic signed [TW_WIDTH-1:0] SV = tw_val(g, 1'b1);
      assign rom_c[g] = CV;
      assign rom_s[g] = SV;
   end

   logic [LOG2N-1:0] cnt, idx, k;
   logic [H-1:0]     col, row, col_rev;
   logic [2:0]       oct;
   logic [PW-1:0]    p;
   logic [MW-1:0]    m;
   logic             inv_f, inv_eff, stall, en;
   logic [STAGES:1]  vld_pipe, sof_pipe, last_pipe;

   logic signed [TW_WIDTH-1:0]      cos1, sin1, cos_t, sin_t, wr, wi;
   logic [2:0]                      oct1;
   logic signed [DATA_WIDTH_IN-1:0] xr1, xi1;
   logic                            inv1;
   logic signed [PRW-1:0]           p_rr, p_ii, p_ri, p_ir;

   assign stall     = vld_pipe[STAGES] && !out_ready;
   assign en        = !stall;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES];
   assign out_sof   = sof_pipe[STAGES];
   assign out_last  = last_pipe[STAGES];

   // Stage 0: sample index -> exponent -> folded ROM address
   always_comb begin
      idx     = in_sof ? '0 : cnt;
      col     = idx[LOG2N-1:H];
      row     = idx[H-1:0];
      col_rev = '0;
      for (int i = 0; i < H; i++) col_rev[i] = col[H-1-i];
      k       = {{H{1'b0}}, col_rev} * {{H{1'b0}}, row};
      oct     = k[LOG2N-1:LOG2N-3];
      p       = k[PW-1:0];
      m       = oct[0] ? MW'(NE) - {1'b0, p} : {1'b0, p};
      inv_eff = (idx == '0) ? inv : inv_f;
   end

   // Stage 2 front: unfold octant back to full-circle (cos, sin)
   always_comb begin
      cos_t = cos1;
      sin_t = sin1;
      unique case (oct1)
         3'd0: begin cos_t =  cos1; sin_t =  sin1; end
         3'd1: begin cos_t =  sin1; sin_t =  cos1; end
         3'd2: begin cos_t = -sin1; sin_t =  cos1; end
         3'd3: begin cos_t = -cos1; sin_t =  sin1; end
         3'd4: begin cos_t = -cos1; sin_t = -sin1; end
         3'd5: begin cos_t = -sin1; sin_t = -cos1; end
         3'd6: begin cos_t =  sin1; sin_t = -cos1; end
         3'd7: begin cos_t =  cos1; sin_t = -sin1; end
      endcase
      wr = cos_t;
      wi = inv1 ? sin_t : -sin_t;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         inv_f     <= 1'b0;
         vld_pipe  <= '0;
         sof_pipe  <= '0;
         last_pipe <= '0;
         dout_real <= '0;
         dout_imag <= '0;
      end else if (en) begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
         sof_pipe  <= {sof_pipe[STAGES-1:1], in_valid && (idx == '0)};
         last_pipe <= {last_pipe[STAGES-1:1], in_valid && (idx == LOG2N'(N - 1))};
         if (in_valid) begin
            cnt <= idx + LOG2N'(1);
            if (idx == '0) inv_f <= inv;
         end
         // Output only moves on real samples so it stays clean across bubbles
         if (vld_pipe[STAGES-1]) begin
            dout_real <= rnd_sat(SW'(p_rr) - SW'(p_ii));
            dout_imag <= rnd_sat(SW'(p_ri) + SW'(p_ir));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         cos1 <= rom_c[m];
         sin1 <= rom_s[m];
         oct1 <= oct;
         xr1  <= din_real;
         xi1  <= din_imag;
         inv1 <= inv_eff;
         p_rr <= PRW'(xr1) * PRW'(wr);
         p_ii <= PRW'(xi1) * PRW'(wi);
         p_ri <= PRW'(xr1) * PRW'(wi);
         p_ir <= PRW'(xi1) * PRW'(wr);
      end
   end

endmodule

// File: tb/tb_dif_radix2_tm_gen.sv
// Bench for dif_radix2_tm_gen: random streams against a trig/integer reference model,
// plus fixed-value cases; a second instance with 10-bit output covers saturation.
module tb_dif_radix2_tm_gen;

   localparam int    DIN = 10, DOUT = 11, DOUT_S = 10, LOG2N = 6, TW = 12;
   localparam int    N = 64, R = 8, H = 3;
   localparam real   PI = 3.141592653589793;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic in_valid = 1'b0, in_sof = 1'b0, inv = 1'b0, out_ready = 1'b1;
   logic signed [DIN-1:0]    din_real = '0, din_imag = '0;
   logic                     in_ready, out_valid, out_sof, out_last;
   logic signed [DOUT-1:0]   dout_real, dout_imag;
   logic                     s_in_ready, s_out_valid, s_out_sof, s_out_last;
   logic signed [DOUT_S-1:0] s_dout_real, s_dout_imag;

   dif_radix2_tm_gen #(.DATA_WIDTH_IN(DIN), .DATA_WIDTH_OUT(DOUT), .LOG2N(LOG2N), .TW_WIDTH(TW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .inv(inv),
      .din_real(din_real), .din_imag(din_imag), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_last(out_last), .dout_real(dout_real), .dout_imag(dout_imag));

   dif_radix2_tm_gen #(.DATA_WIDTH_IN(DIN), .DATA_WIDTH_OUT(DOUT_S), .LOG2N(LOG2N), .TW_WIDTH(TW)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_sof(in_sof), .inv(inv),
      .din_real(din_real), .din_imag(din_imag), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sof(s_out_sof), .out_last(s_out_last), .dout_real(s_dout_real), .dout_imag(s_dout_imag));

   typedef struct {
      int er, ei, sr, si;
      bit sof, last;
      int cyc, stl;
      bit dir, dsof;
      int dr, di, dsr, dsi;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, stall_cnt = 0, m_cnt = 0, rdy_pct = 100, bp_lo = 0, bp_hi = 0;
   bit   m_inv = 1'b0, acc = 1'b0;
   bit   dir_en = 1'b0, dir_sof = 1'b0;
   int   dir_r, dir_i, dir_sr, dir_si;
   bit   hold_vld = 1'b0;
   int   hold_r, hold_i, hold_sof, hold_last;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   function automatic int bitrev(input int v, input int w);
      int r = 0;
      for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx = (1 << (w - 1)) - 1;
      if (v > mx) return mx;
      if (v < -mx - 1) return -mx - 1;
      return v;
   endfunction

   // Reference: exact quantised twiddle from trig, then integer product, round half up, saturate
   task automatic model(input int idx, input bit iv, input int xr, input int xi,
                        output int yr, output int yi, output int syr, output int syi);
      int  kk, c, s, wi, pr, pi;
      real th;
      kk = bitrev(idx / R, H) * (idx % R);
      th = 2.0 * PI * real'(kk) / real'(N);
      c  = rnd($cos(th) * 1024.0);
      s  = rnd($sin(th) * 1024.0);
      wi = iv ? s : -s;
      pr = (xr * c - xi * wi + 512) >>> 10;
      pi = (xr * wi + xi * c + 512) >>> 10;
      yr = sat(pr, DOUT);   yi = sat(pi, DOUT);
      syr = sat(pr, DOUT_S); syi = sat(pi, DOUT_S);
   endtask

   task automatic tick();
      bit   stalled, in_bp;
      exp_t e;
      int   idx;
      @(negedge clk);
      stalled = out_valid && !out_ready;
      in_bp   = (cyc >= bp_lo) && (cyc < bp_hi);
      acc     = 1'b0;
      if (rst_n) begin
         chk("in_ready", in_ready, !stalled);
         chk("sat_in_ready", s_in_ready, !stalled);
      end
      if (in_bp && out_valid) chk("bp_in_ready", in_ready, 0);
      if (hold_vld) begin
         chk("hold_real", dout_real, hold_r);
         chk("hold_imag", dout_imag, hold_i);
         chk("hold_sof", out_sof, hold_sof);
         chk("hold_last", out_last, hold_last);
      end
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", 1, 0);
         else begin
            e = q.pop_front();
            chk("dout_real", dout_real, e.er);
            chk("dout_imag", dout_imag, e.ei);
            chk("out_sof", out_sof, e.sof);
            chk("out_last", out_last, e.last);
            chk("latency", cyc, e.cyc + 3 + (stall_cnt - e.stl));
            chk("sat_valid", s_out_valid, 1);
            chk("sat_real", s_dout_real, e.sr);
            chk("sat_imag", s_dout_imag, e.si);
            chk("sat_sof", s_out_sof, e.sof);
            chk("sat_last", s_out_last, e.last);
            if (e.dir) begin
               chk("dir_real", dout_real, e.dr);
               chk("dir_imag", dout_imag, e.di);
               chk("dir_sat_real", s_dout_real, e.dsr);
               chk("dir_sat_imag", s_dout_imag, e.dsi);
               chk("dir_sof", out_sof, e.dsof);
            end
         end
      end
      if (rst_n && in_valid && in_ready) begin
         acc = 1'b1;
         idx = in_sof ? 0 : m_cnt;
         if (idx == 0) m_inv = inv;
         model(idx, m_inv, din_real, din_imag, e.er, e.ei, e.sr, e.si);
         e.sof = (idx == 0); e.last = (idx == N - 1);
         e.cyc = cyc; e.stl = stall_cnt;
         e.dir = dir_en; e.dsof = dir_sof;
         e.dr = dir_r; e.di = dir_i; e.dsr = dir_sr; e.dsi = dir_si;
         dir_en = 1'b0;
         q.push_back(e);
         m_cnt = (idx + 1) % N;
      end
      if (stalled) stall_cnt++;
      hold_vld = stalled && rst_n;
      hold_r = dout_real; hold_i = dout_imag; hold_sof = out_sof; hold_last = out_last;
      if (!rst_n) begin
         q.delete(); m_cnt = 0; m_inv = 1'b0; hold_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      out_ready = ((cyc >= bp_lo) && (cyc < bp_hi)) ? 1'b0 : ($urandom_range(99) < rdy_pct);
   endtask

   task automatic send(input int xr, input int xi, input bit sof, input bit iv);
      int budget = 0;
      in_valid = 1'b1; in_sof = sof; inv = iv;
      din_real = DIN'(xr); din_imag = DIN'(xi);
      acc = 1'b0;
      while (!acc && budget < 200) begin tick(); budget++; end
      if (!acc) chk("send_timeout", 0, 1);
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic send_d(input int xr, input int xi, input bit sof, input bit iv,
                         input int er, input int ei, input int sr, input int si, input bit esof);
      dir_en = 1'b1; dir_sof = esof;
      dir_r = er; dir_i = ei; dir_sr = sr; dir_si = si;
      send(xr, xi, sof, iv);
   endtask

   function automatic int rdat();
      return int'($urandom_range(1023)) - 512;
   endfunction

   task automatic drain();
      int budget = 0;
      in_valid = 1'b0; rdy_pct = 100;
      while (q.size() != 0 && budget < 500) begin tick(); budget++; end
      chk("drain", q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout_real", dout_real, 0);
      chk("rst_dout_imag", dout_imag, 0);
      chk("rst_out_sof", out_sof, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);

      // Forward frame with identity, k=8 and k=16 points
      rdy_pct = 100;
      for (int i = 0; i < N; i++) begin
         if (i == 0)       send_d(5, 7, 1, 0, 5, 7, 5, 7, 1);
         else if (i == 2)  send_d(123, -45, 0, 0, 123, -45, 123, -45, 0);
         else if (i == 10) send_d(100, 100, 0, 0, 141, 0, 141, 0, 0);
         else if (i == 12) send_d(100, 50, 0, 0, 50, -100, 50, -100, 0);
         else              send(rdat(), rdat(), 0, 1'($urandom_range(1)));
      end
      // Inverse frame
      for (int i = 0; i < N; i++) begin
         if (i == 10) send_d(100, 100, 0, 1, 0, 141, 0, 141, 0);
         else         send(rdat(), rdat(), i == 0, (i == 0) ? 1'b1 : 1'($urandom_range(1)));
      end
      // Saturation at k=8 on the narrow instance
      for (int i = 0; i < N; i++) begin
         if (i == 10) send_d(511, 511, 0, 0, 723, 0, 511, 0, 0);
         else         send(rdat(), rdat(), i == 0, 1'b0);
      end
      drain();

      // Five cycles of backpressure mid-stream
      bp_lo = cyc + 25; bp_hi = bp_lo + 5;
      for (int i = 0; i < N; i++) send(rdat(), rdat(), i == 0, 1'b0);
      drain();

      // Random streams: gaps, random ready, per-sample inv, occasional resync
      for (int f = 0; f < 6; f++) begin
         rdy_pct = 55 + 8 * f;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(4) == 0) begin in_valid = 1'b0; tick(); end
            send(rdat(), rdat(), (i == 0) || ($urandom_range(49) == 0), 1'($urandom_range(1)));
         end
      end
      drain();

      // Resync on the 20th sample of a frame
      for (int i = 0; i < 25; i++) begin
         if (i == 19) send_d(77, -33, 1, 0, 77, -33, 77, -33, 1);
         else         send(rdat(), rdat(), i == 0, 1'b0);
      end
      drain();

      // Reset with three samples in flight held by backpressure
      bp_lo = cyc + 2; bp_hi = cyc + 1000;
      for (int i = 0; i < 3; i++) send(rdat(), rdat(), i == 0, 1'b0);
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_dout_real", dout_real, 0);
      tick(); tick();
      bp_hi = cyc; out_ready = 1'b1;
      send_d(200, -100, 0, 1'b0, 200, -100, 200, -100, 1);
      for (int i = 1; i < 8; i++) send(rdat(), rdat(), 1'b0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
